// File: rtl/uart_echo_engine_pkg.sv
// rtl/uart_echo_engine_pkg.sv - shared encodings for the UART echo engine
//
// Purpose: transform-mode and FSM state encodings used by the engine, its
// transform sub-module and the testbench.
// Ports: none (package).

package uart_echo_engine_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_ADD  = 2'b01,
    MODE_CASE = 2'b10,
    MODE_REV  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Bit flipped by the case transform (ASCII upper/lower case).
  localparam int CASE_BIT = 5;

endpackage

// File: rtl/uart_byte_xform.sv
// rtl/uart_byte_xform.sv - combinational word transform for the echo engine
//
// Purpose: applies the selected transform to one received word.
// Ports:
//   i_data  DBIT  raw word
//   i_mode  2     transform select (mode_e)
//   o_data  DBIT  transformed word

import uart_echo_engine_pkg::*;

module uart_byte_xform #(
  parameter int DBIT = 8,
  parameter int INC  = 1
) (
  input  logic [DBIT-1:0] i_data,
  input  logic [1:0]      i_mode,
  output logic [DBIT-1:0] o_data
);

  // Truncating INC to DBIT bits gives the mod 2^DBIT addition for free.
  localparam logic [DBIT-1:0] W_INC = DBIT'(INC);

  logic [DBIT-1:0] w_case_mask;
  logic [DBIT-1:0] w_rev;

  // Narrow words have no case bit, so the case transform degrades to pass.
  generate
    if (DBIT > CASE_BIT) begin : g_case
      assign w_case_mask = DBIT'(1) << CASE_BIT;
    end else begin : g_nocase
      assign w_case_mask = '0;
    end
  endgenerate

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < DBIT; i++) begin
      w_rev[i] = i_data[DBIT-1-i];
    end
  end

  always_comb begin
    o_data = i_data;
    case (mode_e'(i_mode))
      MODE_PASS: o_data = i_data;
      MODE_ADD:  o_data = i_data + W_INC;
      MODE_CASE: o_data = i_data ^ w_case_mask;
      MODE_REV:  o_data = w_rev;
      default:   o_data = i_data;
    endcase
  end

endmodule

// File: rtl/uart_echo_engine.sv
// rtl/uart_echo_engine.sv - autonomous UART echo controller
//
// Purpose: pops words from the rx FIFO (automatically or per step tick),
// transforms them and pushes each result 1..2^REP_W-1 times to the tx FIFO.
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_auto_en, i_step        autonomous enable, single-cycle step tick
//   i_mode, i_rep            transform select, copies per word (0 -> 1)
//   i_rx_empty, i_r_data     rx FIFO status and first-word-fall-through head
//   o_rd_uart                rx FIFO pop strobe
//   i_tx_full                tx FIFO full
//   o_w_data, o_wr_uart      tx FIFO word and push strobe
//   o_last_data              last raw word popped
//   o_rx_count, o_tx_count   wrapping traffic counters
//   o_busy                   high while sending a burst

import uart_echo_engine_pkg::*;

module uart_echo_engine #(
  parameter int DBIT  = 8,
  parameter int INC   = 1,
  parameter int REP_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_auto_en,
  input  logic             i_step,
  input  logic [1:0]       i_mode,
  input  logic [REP_W-1:0] i_rep,
  input  logic             i_rx_empty,
  input  logic [DBIT-1:0]  i_r_data,
  output logic             o_rd_uart,
  input  logic             i_tx_full,
  output logic [DBIT-1:0]  o_w_data,
  output logic             o_wr_uart,
  output logic [DBIT-1:0]  o_last_data,
  output logic [CNT_W-1:0] o_rx_count,
  output logic [CNT_W-1:0] o_tx_count,
  output logic             o_busy
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [DBIT-1:0]  r_hold;
  logic [DBIT-1:0]  r_last;
  logic [REP_W-1:0] r_remain;
  logic             r_step_pend;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [CNT_W-1:0] r_tx_cnt;

  logic             w_go;
  logic             w_pop;
  logic             w_push;
  logic [DBIT-1:0]  w_xform;

  uart_byte_xform #(
    .DBIT (DBIT),
    .INC  (INC)
  ) u_xform (
    .i_data (i_r_data),
    .i_mode (i_mode),
    .o_data (w_xform)
  );

  assign w_go = !i_rx_empty && (i_auto_en || i_step || r_step_pend);

  // Strobes are gated by reset so nothing moves in the reset cycle itself.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    if (!i_reset) begin
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_SEND;
          end
        end
        ST_SEND: begin
          if (!i_tx_full) begin
            w_push = 1'b1;
            if (r_remain == REP_W'(1)) begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_last      <= '0;
      r_remain    <= '0;
      r_step_pend <= 1'b0;
      r_rx_cnt    <= '0;
      r_tx_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;

      // mode and rep are captured here only, so a burst is immune to later changes.
      if (w_pop) begin
        r_hold   <= w_xform;
        r_last   <= i_r_data;
        r_remain <= (i_rep == '0) ? REP_W'(1) : i_rep;
        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
      end

      if (w_push) begin
        r_remain <= r_remain - REP_W'(1);
        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
      end

      // One-deep step memory: extra steps before consumption merge into one.
      if (i_auto_en || w_pop) begin
        r_step_pend <= 1'b0;
      end else if (i_step) begin
        r_step_pend <= 1'b1;
      end
    end
  end

  assign o_rd_uart   = w_pop;
  assign o_wr_uart   = w_push;
  assign o_w_data    = r_hold;
  assign o_last_data = r_last;
  assign o_rx_count  = r_rx_cnt;
  assign o_tx_count  = r_tx_cnt;
  assign o_busy      = (r_state == ST_SEND);

endmodule

// File: tb/tb_uart_echo_engine.sv
// tb/tb_uart_echo_engine.sv - scoreboard testbench for uart_echo_engine

module tb_uart_echo_engine;

  localparam int DBIT  = 8;
  localparam int INC   = 1;
  localparam int REP_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             auto_en = 1'b0;
  logic             step = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [REP_W-1:0] rep = 4'd1;
  logic             rx_empty = 1'b1;
  logic [DBIT-1:0]  r_data = '0;
  logic             tx_full = 1'b0;
  logic             rd_uart;
  logic             wr_uart;
  logic             busy;
  logic [DBIT-1:0]  w_data;
  logic [DBIT-1:0]  last_data;
  logic [CNT_W-1:0] rx_count;
  logic [CNT_W-1:0] tx_count;

  int n_total = 0;
  int n_pass  = 0;
  int tx_seen = 0;
  int rx_seen = 0;
  bit rand_bp = 1'b0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  uart_echo_engine #(
    .DBIT (DBIT), .INC (INC), .REP_W (REP_W), .CNT_W (CNT_W)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_auto_en   (auto_en),
    .i_step      (step),
    .i_mode      (mode),
    .i_rep       (rep),
    .i_rx_empty  (rx_empty),
    .i_r_data    (r_data),
    .o_rd_uart   (rd_uart),
    .i_tx_full   (tx_full),
    .o_w_data    (w_data),
    .o_wr_uart   (wr_uart),
    .o_last_data (last_data),
    .o_rx_count  (rx_count),
    .o_tx_count  (tx_count),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference transform from the word-level rules, using plain arithmetic.
  function automatic int ref_xform(input int w, input int m);
    int r;
    case (m)
      0: r = w;
      1: r = (w + INC) % 256;
      2: r = (((w / 32) % 2) == 1) ? w - 32 : w + 32;
      3: begin
        r = 0;
        for (int i = 0; i < 8; i++)
          if (((w >> i) % 2) == 1) r += (1 << (7 - i));
      end
      default: r = w;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Adds a word to the rx FIFO model and the copies it must produce to the scoreboard.
  task automatic enqueue(input int w);
    int n;
    rx_q.push_back(8'(w));
    n = (rep == 0) ? 1 : int'(rep);
    for (int k = 0; k < n; k++) exp_q.push_back(8'(ref_xform(w, int'(mode))));
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (rx_q.size() == 0 && exp_q.size() == 0 && !busy) break;
      if (rand_bp) tx_full = ($urandom_range(0, 2) == 0);
      tick();
    end
    tx_full = 1'b0;
    check({name, "_drain"}, (i < budget) ? 1 : 0, 1);
  endtask

  // rx FIFO model: first-word-fall-through, pops take effect at the clock edge.
  initial begin
    bit p;
    forever begin
      @(negedge clk);
      p = rd_uart && !reset;
      @(posedge clk);
      #1;
      if (p && rx_q.size() > 0) void'(rx_q.pop_front());
      rx_empty = (rx_q.size() == 0);
      r_data   = rx_empty ? 8'h00 : rx_q[0];
    end
  end

  // Monitor: pops the scoreboard on every push and checks strobe rules.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (wr_uart) begin
          tx_seen++;
          check("wr_while_full", tx_full, 0);
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_push: got 0x%0h expected none", w_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", w_data, e);
          end
        end
        if (rd_uart) begin
          rx_seen++;
          check("rd_while_empty", rx_empty, 0);
          check("rd_wr_overlap", wr_uart, 0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base_rx, base_tx, busy_cycles, i;
    bit changed, stable_ok;

    // Reset values
    repeat (3) tick();
    @(negedge clk);
    check("rst_rd_uart", rd_uart, 0);
    check("rst_wr_uart", wr_uart, 0);
    check("rst_busy", busy, 0);
    check("rst_w_data", w_data, 0);
    check("rst_last_data", last_data, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_tx_count", tx_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // Auto, add transform including wrap 0xFF -> 0x00
    mode = 2'b01; rep = 4'd1; auto_en = 1'b1;
    enqueue(8'h41); enqueue(8'hFF);
    wait_drain("auto_add", 50);
    check("add_rx_count", rx_count, 2);
    check("add_tx_count", tx_count, 2);
    check("add_last_data", last_data, 8'hFF);

    // Manual, case toggle, one word per step
    auto_en = 1'b0; mode = 2'b10; rep = 4'd1;
    tick();
    base_rx = rx_seen; base_tx = tx_seen;
    enqueue(8'h61); enqueue(8'h5A);
    repeat (8) tick();
    check("man_no_pop", rx_seen - base_rx, 0);
    pulse_step();
    repeat (8) tick();
    check("man_step1_pops", rx_seen - base_rx, 1);
    check("man_step1_pushes", tx_seen - base_tx, 1);
    pulse_step();
    repeat (8) tick();
    check("man_step2_pops", rx_seen - base_rx, 2);
    check("man_step2_pushes", tx_seen - base_tx, 2);

    // Auto, bit reverse, rep=3; rep changed mid-burst has no effect
    auto_en = 1'b1; mode = 2'b11; rep = 4'd3;
    base_tx = tx_seen;
    enqueue(8'h01);
    busy_cycles = 0; changed = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) begin
        busy_cycles++;
        if (!changed) begin rep = 4'd5; changed = 1'b1; end
      end
    end
    @(posedge clk); #1;
    check("rev_busy_cycles", busy_cycles, 3);
    check("rev_pushes", tx_seen - base_tx, 3);
    rep = 4'd1;

    // Backpressure: 10 stalled cycles, then push on first free cycle
    mode = 2'b00; rep = 4'd1; tx_full = 1'b1;
    base_tx = tx_seen;
    enqueue(8'h33);
    for (i = 0; i < 10 && !busy; i++) tick();
    check("bp_in_send", busy, 1);
    stable_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wr_uart || w_data != 8'h33) stable_ok = 1'b0;
    end
    check("bp_stall_stable", stable_ok, 1);
    @(posedge clk); #1;
    tx_full = 1'b0;
    @(negedge clk);
    check("bp_first_push", wr_uart, 1);
    @(posedge clk); #1;
    wait_drain("bp", 20);
    check("bp_pushes", tx_seen - base_tx, 1);

    // Step while empty is remembered
    auto_en = 1'b0; mode = 2'b00; rep = 4'd1;
    tick();
    base_rx = rx_seen; base_tx = tx_seen;
    pulse_step();
    repeat (20) tick();
    enqueue(8'h10);
    repeat (10) tick();
    check("pend_pops", rx_seen - base_rx, 1);
    check("pend_pushes", tx_seen - base_tx, 1);

    // Two steps during SEND give one extra pop
    tx_full = 1'b1;
    base_rx = rx_seen;
    enqueue(8'hA1); enqueue(8'hA2); enqueue(8'hA3);
    repeat (3) tick();
    pulse_step();
    repeat (3) tick();
    check("merge_in_send", busy, 1);
    pulse_step();
    tick();
    pulse_step();
    repeat (3) tick();
    tx_full = 1'b0;
    repeat (20) tick();
    check("merge_pops", rx_seen - base_rx, 2);
    check("merge_fifo_left", rx_q.size(), 1);
    pulse_step();
    repeat (10) tick();
    check("merge_pops_final", rx_seen - base_rx, 3);
    check("merge_sb_empty", exp_q.size(), 0);

    // Reset mid-burst after two of four copies
    auto_en = 1'b1; mode = 2'b00; rep = 4'd4;
    base_tx = tx_seen;
    enqueue(8'h5C); enqueue(8'h77);
    for (i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (tx_seen - base_tx >= 2) break;
    end
    check("rstmid_two_pushes", (i < 40) ? 1 : 0, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_no_wr", wr_uart, 0);
    check("rstmid_no_rd", rd_uart, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_busy", busy, 0);
    check("rstmid_w_data", w_data, 0);
    check("rstmid_last", last_data, 0);
    check("rstmid_rx_count", rx_count, 0);
    check("rstmid_tx_count", tx_count, 0);
    check("rstmid_fifo_kept", rx_q.size(), 1);
    // Discard the two copies of 0x5C that reset abandoned.
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge clk); #1;
    reset = 1'b0;
    wait_drain("rstmid", 50);
    check("rstmid_rx_after", rx_count, 1);
    check("rstmid_tx_after", tx_count, 4);
    check("rstmid_last_after", last_data, 8'h77);

    // Randomized traffic with random backpressure
    rand_bp = 1'b1;
    for (int r = 0; r < 12; r++) begin
      int n;
      mode = 2'($urandom_range(0, 3));
      rep  = 4'($urandom_range(0, 5));
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) enqueue($urandom_range(0, 255));
      wait_drain("rand", 400);
    end
    rand_bp = 1'b0;
    tick();
    check("final_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
